// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the fetch stage.
// Owns the architectural PC, selects the next fetch address from
// sequential / branch / jump / call / return, keeps a circular
// return-address stack and a RUN/HALTED debug state machine.
// Every output comes straight from a register; inputs only steer
// the next-state logic.
module pc_sequencer #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [WIDTH-1:0]  STEP      = WIDTH'(1),
  parameter int                RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             halt,
  input  logic                             resume,
  input  logic                             branch_taken,
  input  logic [WIDTH-1:0]                 branch_target,
  input  logic                             jump,
  input  logic                             call,
  input  logic [WIDTH-1:0]                 jump_target,
  input  logic                             ret,
  output logic [WIDTH-1:0]                 pc,
  output logic                             halted,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_overflow,
  output logic                             ras_underflow
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  // PC arithmetic is modulo 2^WIDTH: the sum is simply truncated.
  function automatic logic [WIDTH-1:0] pc_add(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    pc_add = a + b;
  endfunction

  // Stack pointer advance, wrapping at RAS_DEPTH (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Stack pointer retreat, wrapping at RAS_DEPTH.
  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    ptr_dec = (p == '0) ? PTR_LAST : p - PTR_W'(1);
  endfunction

  state_t             state_q;
  state_t             state_nxt;
  logic [WIDTH-1:0]   pc_q;
  logic [WIDTH-1:0]   pc_nxt;
  logic [WIDTH-1:0]   seq_pc;
  logic [CNT_W-1:0]   cnt_q;
  logic [PTR_W-1:0]   wp_q;
  logic               ovf_q;
  logic               udf_q;
  logic               do_push;
  logic               do_pop;
  logic               set_ovf;
  logic               set_udf;

  // wp_q is the next slot to write; the top of stack sits one below it.
  // When the stack is full, wp_q lands on the oldest entry, so a push
  // there overwrites exactly the entry that must be dropped.
  logic [WIDTH-1:0]   ras_mem [RAS_DEPTH];

  assign seq_pc = pc_add(pc_q, STEP);

  // State register: RUN/HALTED, forced to RUN by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic: halt wins in RUN, resume wins in HALTED.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      RUN:     if (halt)   state_nxt = HALTED;
      HALTED:  if (resume) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Next-PC selection and stack control; only RUN without halt/stall acts.
  always_comb begin
    pc_nxt  = pc_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    if (state_q == RUN && !halt && !stall) begin
      if (ret) begin
        if (cnt_q != '0) begin
          pc_nxt = ras_mem[ptr_dec(wp_q)];
          do_pop = 1'b1;
        end else begin
          pc_nxt  = seq_pc;
          set_udf = 1'b1;
        end
      end else if (call) begin
        pc_nxt  = jump_target;
        do_push = 1'b1;
        set_ovf = (cnt_q == RAS_FULL);
      end else if (jump) begin
        pc_nxt = jump_target;
      end else if (branch_taken) begin
        pc_nxt = branch_target;
      end else begin
        pc_nxt = seq_pc;
      end
    end
  end

  // PC, stack pointer, occupancy and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      wp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      if (do_push) begin
        wp_q <= ptr_inc(wp_q);
        if (cnt_q != RAS_FULL) cnt_q <= cnt_q + CNT_W'(1);
      end else if (do_pop) begin
        wp_q  <= ptr_dec(wp_q);
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (set_ovf) ovf_q <= 1'b1;
      if (set_udf) udf_q <= 1'b1;
    end
  end

  // Return-address storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      ras_mem[wp_q] <= seq_pc;
    end
  end

  // Outputs are direct register views.
  always_comb begin
    pc            = pc_q;
    halted        = (state_q == HALTED);
    ras_count     = cnt_q;
    ras_overflow  = ovf_q;
    ras_underflow = udf_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the sequencer.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall, halt, resume, branch_taken, jump, call, ret;
  logic [7:0] branch_target, jump_target;
  logic [7:0] pc;
  logic       halted;
  logic [2:0] ras_count;
  logic       ras_overflow, ras_underflow;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] m_pc;
  logic       m_halted;
  logic [7:0] m_stack[$];
  logic       m_ovf, m_udf;

  pc_sequencer #(
    .WIDTH(8), .RESET_PC(8'h10), .STEP(8'h01), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .call(call), .jump_target(jump_target), .ret(ret),
    .pc(pc), .halted(halted), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    reset = 1'b1; stall = 1'b0; halt = 1'b0; resume = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    branch_target = 8'h00; jump_target = 8'h00;
  endtask

  // Advance the model by one decision using the present inputs.
  task automatic model_step();
    logic [7:0] tmp;
    if (!reset) begin
      m_pc = 8'h10; m_halted = 1'b0; m_stack.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else if (m_halted) begin
      if (resume) m_halted = 1'b0;
    end else if (halt) begin
      m_halted = 1'b1;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (ret) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin m_pc = m_pc + 8'd1; m_udf = 1'b1; end
    end else if (call) begin
      m_stack.push_back(m_pc + 8'd1);
      if (m_stack.size() > 4) begin tmp = m_stack.pop_front(); m_ovf = 1'b1; end
      m_pc = jump_target;
    end else if (jump) begin
      m_pc = jump_target;
    end else if (branch_taken) begin
      m_pc = branch_target;
    end else begin
      m_pc = m_pc + 8'd1;
    end
  endtask

  // Apply present inputs for one edge; sample 1 time unit after it.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13};
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (pc !== exp_seq[0] || halted !== 1'b0 || ras_count !== 3'd0 ||
        ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pc=%h halted=%b cnt=%0d ovf=%b udf=%b required pc=10 0 0 0 0",
               pc, halted, ras_count, ras_overflow, ras_underflow);
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if (pc !== exp_seq[i]) begin
        errors++;
        $display("FAIL reset_seq[%0d] pc=%h required %h", i, pc, exp_seq[i]);
      end
    end
  endtask

  task automatic test_wrap_priority();
    idle_inputs();
    jump = 1'b1; jump_target = 8'hFF;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL wrap pc=%h required 00", pc); end
    jump = 1'b1; jump_target = 8'h40; branch_taken = 1'b1; branch_target = 8'h80;
    tick();
    idle_inputs();
    checks++;
    if (pc !== 8'h40) begin errors++; $display("FAIL jump_over_branch pc=%h required 40", pc); end
    branch_taken = 1'b1; branch_target = 8'h80;
    tick();
    idle_inputs();
    checks++;
    if (pc !== 8'h80) begin errors++; $display("FAIL branch pc=%h required 80", pc); end
  endtask

  task automatic test_call_ret();
    logic [7:0] exp_pc [4];
    logic [2:0] exp_cnt [4];
    exp_pc  = '{8'h50, 8'h60, 8'h51, 8'h21};
    exp_cnt = '{3'd1, 3'd2, 3'd1, 3'd0};
    idle_inputs();
    jump = 1'b1; jump_target = 8'h20;
    tick();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      if (i == 0) begin call = 1'b1; jump_target = 8'h50; end
      else if (i == 1) begin call = 1'b1; jump_target = 8'h60; end
      else ret = 1'b1;
      tick();
      checks++;
      if (pc !== exp_pc[i] || ras_count !== exp_cnt[i]) begin
        errors++;
        $display("FAIL call_ret[%0d] pc=%h cnt=%0d required pc=%h cnt=%0d",
                 i, pc, ras_count, exp_pc[i], exp_cnt[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_ras_overflow();
    logic [7:0] exp_pop [5];
    logic [2:0] exp_cnt [5];
    exp_pop = '{8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB2};
    exp_cnt = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    idle_inputs();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      call = 1'b1; jump_target = 8'hB0 + 8'(i);
      tick();
    end
    idle_inputs();
    checks++;
    if (ras_count !== 3'd4 || ras_overflow !== 1'b1 || ras_underflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow cnt=%0d ovf=%b udf=%b required 4 1 0", ras_count, ras_overflow, ras_underflow);
    end
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      ret = 1'b1;
      tick();
      checks++;
      if (pc !== exp_pop[i] || ras_count !== exp_cnt[i]) begin
        errors++;
        $display("FAIL ret_pop[%0d] pc=%h cnt=%0d required pc=%h cnt=%0d",
                 i, pc, ras_count, exp_pop[i], exp_cnt[i]);
      end
    end
    idle_inputs();
    checks++;
    if (ras_underflow !== 1'b1 || ras_overflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow udf=%b ovf=%b required 1 1", ras_underflow, ras_overflow);
    end
  endtask

  task automatic test_halt_stall();
    idle_inputs();
    jump = 1'b1; jump_target = 8'h30;
    tick();
    idle_inputs();
    halt = 1'b1; jump = 1'b1; jump_target = 8'h70;
    tick();
    checks++;
    if (halted !== 1'b1 || pc !== 8'h30) begin
      errors++;
      $display("FAIL halt_entry halted=%b pc=%h required 1 30", halted, pc);
    end
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      jump = i[0]; call = ~i[0]; ret = (i == 2); stall = (i == 3); halt = (i == 4);
      jump_target = 8'h90 + 8'(i); branch_taken = 1'b1; branch_target = 8'hC0;
      tick();
      checks++;
      if (halted !== 1'b1 || pc !== 8'h30 || ras_count !== 3'd0) begin
        errors++;
        $display("FAIL halt_hold[%0d] halted=%b pc=%h cnt=%0d required 1 30 0", i, halted, pc, ras_count);
      end
    end
    idle_inputs();
    resume = 1'b1; halt = 1'b1; jump = 1'b1; jump_target = 8'hEE;
    tick();
    checks++;
    if (halted !== 1'b0 || pc !== 8'h30) begin
      errors++;
      $display("FAIL resume halted=%b pc=%h required 0 30", halted, pc);
    end
    idle_inputs();
    tick();
    checks++;
    if (pc !== 8'h31) begin errors++; $display("FAIL resume_seq pc=%h required 31", pc); end
    for (int i = 0; i < 2; i++) begin
      idle_inputs();
      stall = 1'b1; jump = 1'b1; jump_target = 8'h77;
      tick();
      checks++;
      if (pc !== 8'h31 || halted !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d] pc=%h halted=%b required 31 0", i, pc, halted);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (pc !== 8'h32) begin errors++; $display("FAIL stall_release pc=%h required 32", pc); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    reset = 1'b0;
    tick();
    idle_inputs();
    ret = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      call = 1'b1; jump_target = 8'h60 + 8'(i);
      tick();
    end
    idle_inputs();
    ret = 1'b1;
    tick();
    idle_inputs();
    halt = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (ras_count !== 3'd3 || halted !== 1'b1 || ras_overflow !== 1'b1 || ras_underflow !== 1'b1) begin
      errors++;
      $display("FAIL premid cnt=%0d halted=%b ovf=%b udf=%b required 3 1 1 1",
               ras_count, halted, ras_overflow, ras_underflow);
    end
    reset = 1'b0; stall = 1'b1; jump = 1'b1; jump_target = 8'h99;
    tick();
    idle_inputs();
    checks++;
    if (pc !== 8'h10 || halted !== 1'b0 || ras_count !== 3'd0 ||
        ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid pc=%h halted=%b cnt=%0d ovf=%b udf=%b required 10 0 0 0 0",
               pc, halted, ras_count, ras_overflow, ras_underflow);
    end
    tick();
    checks++;
    if (pc !== 8'h11) begin errors++; $display("FAIL reset_mid_run pc=%h required 11", pc); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      reset         = ($urandom_range(0, 79) != 0);
      stall         = ($urandom_range(0, 7) == 0);
      halt          = ($urandom_range(0, 15) == 0);
      resume        = ($urandom_range(0, 2) == 0);
      ret           = ($urandom_range(0, 4) == 0);
      call          = ($urandom_range(0, 4) == 0);
      jump          = ($urandom_range(0, 5) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      jump_target   = 8'($urandom);
      branch_target = 8'($urandom);
      tick();
      checks++;
      if (pc !== m_pc || halted !== m_halted || ras_count !== 3'(m_stack.size()) ||
          ras_overflow !== m_ovf || ras_underflow !== m_udf) begin
        errors++;
        $display("FAIL random[%0d] pc=%h halted=%b cnt=%0d ovf=%b udf=%b required %h %b %0d %b %b",
                 n, pc, halted, ras_count, ras_overflow, ras_underflow,
                 m_pc, m_halted, m_stack.size(), m_ovf, m_udf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_pc = 8'h00; m_halted = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk);
    test_reset();
    test_wrap_priority();
    test_call_ret();
    test_ras_overflow();
    test_halt_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
